// File: rtl/bcd_key_pkg.sv
// Shared types, state encodings and the round-robin key selector for the
// keypad sequencer.
package bcd_key_pkg;

  localparam int unsigned NUM_KEYS  = 10;
  localparam int unsigned KEY_IDX_W = 4;

  typedef logic [3:0]           bcd_t;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;
  typedef logic [1:0]           state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t GRANT    = 2'd2;
  localparam state_t RELEASE  = 2'd3;

  typedef struct packed {
    logic     found;
    key_idx_t idx;
  } rr_sel_t;

  // First set request bit searching upward from ptr+1, wrapping at NUM_KEYS.
  function automatic rr_sel_t rr_select(input logic [NUM_KEYS-1:0] req,
                                        input key_idx_t ptr);
    rr_sel_t     r;
    int unsigned j;
    key_idx_t    jj;
    r = '0;
    for (int unsigned i = 1; i <= NUM_KEYS; i++) begin
      j  = (32'(ptr) + i) % NUM_KEYS;
      jj = KEY_IDX_W'(j);
      if (!r.found && req[jj]) begin
        r.found = 1'b1;
        r.idx   = jj;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_key_sequencer_onehot_to_bcd.sv
// One-hot decimal to BCD encoder; zero or multi-hot input encodes as 0.
module onehot_to_bcd
  import bcd_key_pkg::*;
(
  input  logic [NUM_KEYS-1:0] onehot,
  output bcd_t                bcd_c
);

  always_comb begin
    bcd_c = '0;
    case (onehot)
      10'b00_0000_0001: bcd_c = 4'd0;
      10'b00_0000_0010: bcd_c = 4'd1;
      10'b00_0000_0100: bcd_c = 4'd2;
      10'b00_0000_1000: bcd_c = 4'd3;
      10'b00_0001_0000: bcd_c = 4'd4;
      10'b00_0010_0000: bcd_c = 4'd5;
      10'b00_0100_0000: bcd_c = 4'd6;
      10'b00_1000_0000: bcd_c = 4'd7;
      10'b01_0000_0000: bcd_c = 4'd8;
      10'b10_0000_0000: bcd_c = 4'd9;
      default:          bcd_c = 4'd0;
    endcase
  end

endmodule

// File: rtl/bcd_key_sequencer.sv
// Debounces decimal keys, arbitrates round-robin, shifts BCD digits into an
// entry register and offers the full entry over valid/ready.
module bcd_key_sequencer
  import bcd_key_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_KEYS-1:0]            key,
  input  logic                           clear,
  input  logic                           out_ready,
  output logic [4*NUM_DIGITS-1:0]        digits_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count,
  output logic                           out_valid,
  output logic                           digit_valid,
  output bcd_t                           digit_bcd
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DBC_W = $clog2(DEBOUNCE_CYCLES + 1);

  state_t              state_q, state_n;
  logic [NUM_KEYS-1:0] pending_q, pending_n;
  logic [DBC_W-1:0]    dbc_q, dbc_n;
  key_idx_t            ptr_q, ptr_n;
  logic [DW-1:0]       digits_n;
  logic [CNT_W-1:0]    count_n;
  logic                digit_valid_n;
  bcd_t                digit_bcd_n;

  rr_sel_t             sel;
  logic                full, handshake, do_grant;
  logic [NUM_KEYS-1:0] grant_vec;
  bcd_t                bcd_c;

  assign full      = (count == CNT_W'(NUM_DIGITS));
  assign out_valid = full;
  assign handshake = full && out_ready;
  assign sel       = rr_select(pending_q, ptr_q);
  // Grant only in GRANT with room, and never on a clear or handshake edge.
  assign do_grant  = (state_q == GRANT) && !full && !handshake && !clear && sel.found;
  assign grant_vec = do_grant ? (NUM_KEYS'(1) << sel.idx) : '0;

  onehot_to_bcd u_enc (
    .onehot (grant_vec),
    .bcd_c  (bcd_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      dbc_q       <= '0;
      ptr_q       <= KEY_IDX_W'(NUM_KEYS - 1);
      digits_out  <= '0;
      count       <= '0;
      digit_valid <= 1'b0;
      digit_bcd   <= '0;
    end else begin
      state_q     <= state_n;
      pending_q   <= pending_n;
      dbc_q       <= dbc_n;
      ptr_q       <= ptr_n;
      digits_out  <= digits_n;
      count       <= count_n;
      digit_valid <= digit_valid_n;
      digit_bcd   <= digit_bcd_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    pending_n     = pending_q;
    dbc_n         = dbc_q;
    ptr_n         = ptr_q;
    digits_n      = digits_out;
    count_n       = count;
    digit_valid_n = 1'b0;
    digit_bcd_n   = digit_bcd;

    case (state_q)
      IDLE: begin
        if (key != '0) begin
          pending_n = key;
          dbc_n     = '0;
          state_n   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (key == pending_q) begin
          if (dbc_q == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
            dbc_n   = '0;
            state_n = GRANT;
          end else begin
            dbc_n = dbc_q + DBC_W'(1);
          end
        end else begin
          pending_n = '0;
          dbc_n     = '0;
          state_n   = IDLE;
        end
      end
      GRANT: begin
        if (do_grant) begin
          digits_n      = (digits_out << 4) | DW'(bcd_c);
          count_n       = count + CNT_W'(1);
          ptr_n         = sel.idx;
          pending_n     = pending_q & ~grant_vec;
          digit_valid_n = 1'b1;
          digit_bcd_n   = bcd_c;
        end
        if (pending_n == '0) state_n = RELEASE;
      end
      RELEASE: begin
        if (key == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (handshake) begin
      digits_n = '0;
      count_n  = '0;
    end

    // Abort wins over everything and waits for the keypad to go quiet.
    if (clear) begin
      digits_n  = '0;
      count_n   = '0;
      pending_n = '0;
      dbc_n     = '0;
      state_n   = RELEASE;
    end
  end

endmodule

// File: tb/tb_bcd_key_sequencer.sv
// Directed self-checking bench for bcd_key_sequencer.
module tb_bcd_key_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  key = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] digits_out;
  logic [2:0]  count;
  logic        out_valid;
  logic        digit_valid;
  logic [3:0]  digit_bcd;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dv  = 0;
  int dv0   = 0;

  bcd_key_sequencer #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .clear       (clear),
    .out_ready   (out_ready),
    .digits_out  (digits_out),
    .count       (count),
    .out_valid   (out_valid),
    .digit_valid (digit_valid),
    .digit_bcd   (digit_bcd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (digit_valid === 1'b1) n_dv++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    key = '0; clear = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  // Hold one key through debounce and write, then release to IDLE.
  task automatic press(input logic [9:0] k);
    key = k;
    step(6);
    key = '0;
    step(2);
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_digits", 32'(digits_out), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_digit_valid", 32'(digit_valid), 32'h0);
    chk("rst_digit_bcd", 32'(digit_bcd), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single press of key 3: write at E0+5
    dv0 = n_dv;
    key = 10'h008;
    step(5);
    chk("single_early", 32'(digit_valid), 32'h0);
    step(1);
    chk("single_dv", 32'(digit_valid), 32'h1);
    chk("single_bcd", 32'(digit_bcd), 32'h3);
    chk("single_digits", 32'(digits_out), 32'h0003);
    chk("single_count", 32'(count), 32'h1);
    key = '0;
    step(3);
    chk("single_pulses", 32'(n_dv - dv0), 32'h1);

    // Bounce: never stable long enough
    do_reset();
    dv0 = n_dv;
    key = 10'h008; step(2);
    key = '0;      step(1);
    key = 10'h008; step(1);
    key = '0;      step(8);
    chk("bounce_pulses", 32'(n_dv - dv0), 32'h0);
    chk("bounce_count", 32'(count), 32'h0);

    // Arbitration: 2,7 from reset then 9,1 after ptr=7
    do_reset();
    key = 10'h084;
    step(6);
    chk("arb_bcd2", 32'(digit_bcd), 32'h2);
    chk("arb_digits2", 32'(digits_out), 32'h0002);
    step(1);
    chk("arb_dv7", 32'(digit_valid), 32'h1);
    chk("arb_bcd7", 32'(digit_bcd), 32'h7);
    chk("arb_digits27", 32'(digits_out), 32'h0027);
    key = '0;
    step(2);
    key = 10'h202;
    step(6);
    chk("arb_bcd9", 32'(digit_bcd), 32'h9);
    step(1);
    chk("arb_bcd1", 32'(digit_bcd), 32'h1);
    chk("arb_digits2791", 32'(digits_out), 32'h2791);
    chk("arb_count4", 32'(count), 32'h4);
    chk("arb_valid", 32'(out_valid), 32'h1);
    key = '0;
    step(2);

    // Full entry, stall, handshake, deferred write
    do_reset();
    press(10'h002);
    press(10'h004);
    press(10'h008);
    press(10'h010);
    chk("full_digits", 32'(digits_out), 32'h1234);
    chk("full_valid", 32'(out_valid), 32'h1);
    chk("full_count", 32'(count), 32'h4);
    dv0 = n_dv;
    key = 10'h020;
    step(9);
    chk("stall_pulses", 32'(n_dv - dv0), 32'h0);
    chk("stall_digits", 32'(digits_out), 32'h1234);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("hs_digits", 32'(digits_out), 32'h0);
    chk("hs_count", 32'(count), 32'h0);
    chk("hs_valid", 32'(out_valid), 32'h0);
    chk("hs_no_write", 32'(digit_valid), 32'h0);
    step(1);
    chk("post_hs_dv", 32'(digit_valid), 32'h1);
    chk("post_hs_bcd", 32'(digit_bcd), 32'h5);
    chk("post_hs_digits", 32'(digits_out), 32'h0005);
    chk("post_hs_count", 32'(count), 32'h1);
    key = '0;
    step(2);

    // Clear while key 4 would be granted
    clear = 1'b1; step(1);
    clear = 1'b0; step(1);
    chk("clr_idle_digits", 32'(digits_out), 32'h0);
    press(10'h100);
    press(10'h040);
    chk("clr_pre_digits", 32'(digits_out), 32'h0086);
    dv0 = n_dv;
    key = 10'h010;
    step(5);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_digits", 32'(digits_out), 32'h0);
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_dv", 32'(digit_valid), 32'h0);
    step(6);
    chk("clr_held_pulses", 32'(n_dv - dv0), 32'h0);
    key = '0;
    step(2);
    press(10'h010);
    chk("clr_repress_digits", 32'(digits_out), 32'h0004);
    chk("clr_repress_pulses", 32'(n_dv - dv0), 32'h1);

    // Reset during debounce
    key = 10'h010;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("mrst_digits", 32'(digits_out), 32'h0);
    chk("mrst_count", 32'(count), 32'h0);
    chk("mrst_bcd", 32'(digit_bcd), 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    step(1);
    rst_n = 1'b1;
    dv0 = n_dv;
    step(5);
    chk("mrst_no_early", 32'(n_dv - dv0), 32'h0);
    step(1);
    chk("mrst_dv", 32'(digit_valid), 32'h1);
    chk("mrst_bcd4", 32'(digit_bcd), 32'h4);
    chk("mrst_digits4", 32'(digits_out), 32'h0004);
    key = '0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
